// File: rtl/regfile_mp_pkg.sv
// Shared types and constant helpers for the multi-port register file.
// Clear-engine state encoding and elaboration-time sizing functions.
package regfile_mp_pkg;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  function automatic int byte_cnt(input int w);
    return w / 8;
  endfunction

  // Loop stops at 30 so that the shifted value never goes negative.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks index 0..DEPTH-1, one register per cycle.
// Busy for exactly DEPTH cycles; requests while busy are ignored.
module regfile_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = clog2_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_vld,
  output logic [IW-1:0] clr_idx
);

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          cnt_d   = '0;
        end
      end
      CLR_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_busy = (state_q == CLR_CLEAR);
  assign clr_vld  = clr_busy;
  assign clr_idx  = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Register file: one byte-enabled write port, two registered read ports with
// write bypass, out-of-range detection, optional zero r0 and a bulk clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 16,
  parameter int ZERO_R0 = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [byte_cnt(WIDTH)-1:0] wr_be,
  input  logic                       rd_en_a,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  output logic [WIDTH-1:0]           rd_data_a,
  output logic                       rd_valid_a,
  input  logic                       rd_en_b,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]           rd_data_b,
  output logic                       rd_valid_b,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       err_addr
);

  localparam int NB  = byte_cnt(WIDTH);
  localparam int IW  = clog2_f(DEPTH);
  localparam int AXW = ADDR_W + 1;
  localparam logic [AXW-1:0] DEPTH_X = AXW'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  rd_data_q [2];
  logic [WIDTH-1:0]  rd_data_d [2];
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic [1:0]        rd_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [1:0]        rd_oor;
  logic              clr_vld;
  logic [IW-1:0]     clr_idx;
  logic              wr_fire, wr_in, wr_eff;
  logic [IW-1:0]     wr_idx;
  logic [WIDTH-1:0]  wr_merged;

  // Full-width compare so aliased high address bits can never hit the array.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  regfile_clr_seq #(.DEPTH(DEPTH), .IW(IW)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_vld  (clr_vld),
    .clr_idx  (clr_idx)
  );

  assign wr_ready = !clr_busy;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_in    = in_range(wr_addr);
  assign wr_idx   = wr_addr[IW-1:0];
  assign wr_eff   = wr_fire && wr_in && !is_r0(wr_addr);

  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // Writes and clears never coincide: the write port is closed while clearing.
  always_comb begin
    mem_d = mem_q;
    if (wr_eff) mem_d[wr_idx] = wr_merged;
    if (clr_vld) mem_d[clr_idx] = '0;
  end

  assign rd_en      = {rd_en_b, rd_en_a};
  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    rd_oor     = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        if (!in_range(rd_addr[p])) begin
          rd_oor[p]    = 1'b1;
          rd_data_d[p] = '0;
        end else if (is_r0(rd_addr[p])) begin
          rd_data_d[p] = '0;
        end else if (wr_eff && (wr_idx == rd_addr[p][IW-1:0])) begin
          rd_data_d[p] = wr_merged;
        end else begin
          rd_data_d[p] = mem_q[rd_addr[p][IW-1:0]];
        end
      end
    end
    err_d = (wr_fire && !wr_in) || (|rd_oor);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      rd_data_q  <= '{default: '0};
      rd_valid_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_data_a  = rd_data_q[0];
  assign rd_data_b  = rd_data_q[1];
  assign rd_valid_a = rd_valid_q[0];
  assign rd_valid_b = rd_valid_q[1];
  assign err_addr   = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_R0=0 and ZERO_R0=1) share stimulus
// and are checked every cycle against an array-based model, plus literal checks.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [15:0] rd_addr_a = '0, rd_addr_b = '0;
  logic        clr_req = 1'b0;

  logic        wr_ready_n, wr_ready_z;
  logic [15:0] rd_data_a_n, rd_data_b_n, rd_data_a_z, rd_data_b_z;
  logic        rd_valid_a_n, rd_valid_b_n, rd_valid_a_z, rd_valid_b_z;
  logic        clr_busy_n, clr_busy_z, err_addr_n, err_addr_z;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(16), .DEPTH(8), .ADDR_W(16), .ZERO_R0(0)) u_dut_n (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_n),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_n), .rd_valid_a(rd_valid_a_n),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_n), .rd_valid_b(rd_valid_b_n),
    .clr_req(clr_req), .clr_busy(clr_busy_n), .err_addr(err_addr_n)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(8), .ADDR_W(16), .ZERO_R0(1)) u_dut_z (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_z),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_z), .rd_valid_a(rd_valid_a_z),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_z), .rd_valid_b(rd_valid_b_z),
    .clr_req(clr_req), .clr_busy(clr_busy_z), .err_addr(err_addr_z)
  );

  // Model state: index 0 = plain instance, 1 = zero-r0 instance.
  logic [15:0] mmem [2][8];
  logic [15:0] exp_rda [2];
  logic [15:0] exp_rdb [2];
  logic        exp_va, exp_vb, exp_err, exp_busy, exp_rdy;
  int          busy_left, clr_pos;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] rd_val(input int z, input logic [15:0] a);
    if (a >= 16'd8) return 16'h0;
    if (z == 1 && a == 16'd0) return 16'h0;
    return mmem[z][a[2:0]];
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 8; i++) mmem[z][i] = 16'h0;
      exp_rda[z] = 16'h0;
      exp_rdb[z] = 16'h0;
    end
    exp_va = 0; exp_vb = 0; exp_err = 0; exp_busy = 0; exp_rdy = 1;
    busy_left = 0; clr_pos = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = wr_valid && (busy_left == 0);
    exp_err = (acc && wr_addr >= 16'd8) ||
              (rd_en_a && rd_addr_a >= 16'd8) || (rd_en_b && rd_addr_b >= 16'd8);
    for (int z = 0; z < 2; z++) begin
      if (acc && wr_addr < 16'd8 && !(z == 1 && wr_addr == 16'd0))
        for (int b = 0; b < 2; b++)
          if (wr_be[b]) mmem[z][wr_addr[2:0]][8*b +: 8] = wr_data[8*b +: 8];
      if (rd_en_a) exp_rda[z] = rd_val(z, rd_addr_a);
      if (rd_en_b) exp_rdb[z] = rd_val(z, rd_addr_b);
    end
    exp_va = rd_en_a;
    exp_vb = rd_en_b;
    if (busy_left > 0) begin
      for (int z = 0; z < 2; z++) mmem[z][clr_pos] = 16'h0;
      clr_pos++;
      busy_left--;
    end else if (clr_req) begin
      busy_left = 8;
      clr_pos   = 0;
    end
    exp_busy = (busy_left > 0);
    exp_rdy  = !exp_busy;
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      chk("n.rd_data_a", rd_data_a_n, exp_rda[0]);
      chk("n.rd_data_b", rd_data_b_n, exp_rdb[0]);
      chk("z.rd_data_a", rd_data_a_z, exp_rda[1]);
      chk("z.rd_data_b", rd_data_b_z, exp_rdb[1]);
      chk("n.rd_valid_a", rd_valid_a_n, exp_va);
      chk("n.rd_valid_b", rd_valid_b_n, exp_vb);
      chk("z.rd_valid_a", rd_valid_a_z, exp_va);
      chk("z.rd_valid_b", rd_valid_b_z, exp_vb);
      chk("n.err_addr", err_addr_n, exp_err);
      chk("z.err_addr", err_addr_z, exp_err);
      chk("n.clr_busy", clr_busy_n, exp_busy);
      chk("z.clr_busy", clr_busy_z, exp_busy);
      chk("n.wr_ready", wr_ready_n, exp_rdy);
      chk("z.wr_ready", wr_ready_z, exp_rdy);
    end
  end

  task automatic set_in(input bit wv, input logic [15:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input bit ea, input logic [15:0] aa,
                        input bit eb, input logic [15:0] ab, input bit cr);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab; clr_req = cr;
  endtask

  task automatic drive(input bit wv, input logic [15:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input bit ea, input logic [15:0] aa,
                       input bit eb, input logic [15:0] ab, input bit cr);
    @(negedge clk);
    set_in(wv, wa, wd, be, ea, aa, eb, ab, cr);
  endtask

  task automatic idle();
    drive(0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r < 11) return 16'($urandom_range(0, 7));
    if (r < 14) return 16'($urandom_range(8, 9));
    return 16'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cyc, bad_rdy;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rd_valid_a", rd_valid_a_n, 0);
    chk("reset rd_data_b", rd_data_b_n, 0);
    chk("reset clr_busy", clr_busy_n, 0);
    chk("reset wr_ready", wr_ready_n, 1);

    // Write then read back.
    drive(1, 16'd3, 16'hBEEF, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 16'd3, 0, 0, 0);
    after_edge();
    chk("t1 rd_data_a", rd_data_a_n, 16'hBEEF);
    chk("t1 rd_valid_a", rd_valid_a_n, 1);

    // Bypass with byte merge on both ports.
    drive(1, 16'd3, 16'h1234, 2'b01, 1, 16'd3, 1, 16'd3, 0);
    after_edge();
    chk("t2 n rd_data_a", rd_data_a_n, 16'hBE34);
    chk("t2 n rd_data_b", rd_data_b_n, 16'hBE34);
    chk("t2 z rd_data_a", rd_data_a_z, 16'hBE34);

    // Out-of-range write and read.
    drive(1, 16'd8, 16'h5A5A, 2'b11, 0, 0, 1, 16'h00FF, 0);
    after_edge();
    chk("t3 err pulse", err_addr_n, 1);
    chk("t3 rd_data_b", rd_data_b_n, 16'h0);
    chk("t3 rd_valid_b", rd_valid_b_n, 1);
    drive(0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    after_edge();
    chk("t3 err drop", err_addr_n, 0);
    chk("t3 addr0 unchanged", rd_data_a_n, 16'h0);

    // Fill, then bulk clear with a write attempted mid-clear.
    for (int i = 0; i < 8; i++) drive(1, 16'(i), 16'hAAAA, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    busy_cyc = 0;
    bad_rdy  = 0;
    for (int k = 0; k < 14; k++) begin
      after_edge();
      if (clr_busy_n) busy_cyc++;
      if (clr_busy_n && wr_ready_n) bad_rdy++;
      if (k == 3) drive(1, 16'd2, 16'h5555, 2'b11, 0, 0, 0, 0, 1);
      else idle();
    end
    chk("t4 busy cycles", busy_cyc, 8);
    chk("t4 wr_ready during clear", bad_rdy, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, 16'(i), 1, 16'(7 - i), 0);
      after_edge();
      chk("t4 cleared a", rd_data_a_n, 16'h0);
      chk("t4 cleared b", rd_data_b_n, 16'h0);
    end

    // Reset in the middle of a clear.
    for (int i = 1; i < 4; i++) drive(1, 16'(i), 16'h1111, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("t5 busy at rst", clr_busy_n, 0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 16'd5, 16'h7777, 2'b11, 0, 0, 0, 0, 0);
    #1;
    chk("t5 wr_ready after rst", wr_ready_n, 1);
    drive(0, 0, 0, 0, 1, 16'd5, 1, 16'd1, 0);
    after_edge();
    chk("t5 write accepted", rd_data_a_n, 16'h7777);
    chk("t5 reg1 zero", rd_data_b_n, 16'h0);

    // Zero r0 behaviour.
    drive(1, 16'd0, 16'hFFFF, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    after_edge();
    chk("t6 z r0 reads zero", rd_data_a_z, 16'h0);
    chk("t6 z no err", err_addr_z, 0);
    chk("t6 n r0 written", rd_data_a_n, 16'hFFFF);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 1), rand_addr(), 16'($urandom), 2'($urandom),
            $urandom_range(0, 1), rand_addr(), $urandom_range(0, 1), rand_addr(),
            $urandom_range(0, 39) == 0);
    end
    idle();
    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
